event_capture_queue: RTL and testbench

- Receiving end of the event/payload handshake: a producer pulses `ev_trig` with `ev_data`, and this block samples the payload race-free, queues it and hands it to a consumer over valid/ready.
- Two sampling disciplines, fixed per instance by parameter:
  - Immediate: sample in the trigger cycle.
  - Deferred: sample one cycle later, so the consumer sees values the producer registered on the trigger edge.
- Sits between event-producing control logic and a slower consumer.

---
 rtl/event_capture_pkg.sv | 13 +
 rtl/ev_fifo.sv | 59 +++++
 rtl/event_capture_queue.sv | 132 +++++++++++++
 tb/tb_event_capture_queue.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/event_capture_pkg.sv
// Shared constants for the event capture queue: sample-mode selectors and
// the occupancy-counter width helper.
package event_capture_pkg;

  localparam int IMMEDIATE = 0;
  localparam int DEFERRED  = 1;

  // Occupancy needs one more bit than the pointers so that "full" is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ev_fifo.sv
// Synchronous DEPTH-entry FIFO with registered head read, used as the
// event queue storage; a pop frees room for a push in the same cycle.
module ev_fifo
  import event_capture_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push_i,
  input  logic                        pop_i,
  input  logic [WIDTH-1:0]            wdata_i,
  output logic [WIDTH-1:0]            rdata_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [cnt_width(DEPTH)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  // Storage is cleared on reset so the head reads 0 while the queue is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/event_capture_queue.sv
// Event capture queue: samples ev_data on a trigger (immediately or one cycle
// later), queues it and tracks drops. Define EVENT_CAPTURE_TS_EN for timestamps.
module event_capture_queue
  import event_capture_pkg::*;
#(
  parameter int DATA_W          = 2,
  parameter int DEPTH           = 4,
  parameter int SAMPLE_DEFERRED = 0,
  parameter int DROP_W          = 8,
  parameter int TS_W            = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ev_trig,
  input  logic [DATA_W-1:0]        ev_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  input  logic                     clr_ovf,
  output logic [DROP_W-1:0]        drop_cnt
`ifdef EVENT_CAPTURE_TS_EN
  ,
  output logic [TS_W-1:0]          out_ts
`endif
);

`ifdef EVENT_CAPTURE_TS_EN
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TS_W-1:0]   ts;
  } entry_t;
`else
  typedef struct packed {
    logic [DATA_W-1:0] data;
  } entry_t;
`endif

  logic   cap_v;
  logic   full, empty, pop, push, drop;
  entry_t cap_e, head_e;

  if (SAMPLE_DEFERRED == DEFERRED) begin : g_deferred
    // Strobe is delayed; payload is sampled live in the delayed cycle.
    logic trig_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) trig_q <= 1'b0;
      else        trig_q <= ev_trig;
    end
    assign cap_v = trig_q;
  end else begin : g_immediate
    assign cap_v = ev_trig;
  end

  assign cap_e.data = ev_data;

`ifdef EVENT_CAPTURE_TS_EN
  logic [TS_W-1:0] ts_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_q + 1'b1;
  end

  // The timestamp always belongs to the trigger cycle, so deferred mode delays it too.
  if (SAMPLE_DEFERRED == DEFERRED) begin : g_ts_deferred
    logic [TS_W-1:0] ts_pipe_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ts_pipe_q <= '0;
      else        ts_pipe_q <= ts_q;
    end
    assign cap_e.ts = ts_pipe_q;
  end else begin : g_ts_immediate
    assign cap_e.ts = ts_q;
  end

  assign out_ts = head_e.ts;
`endif

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign push      = cap_v && (!full || pop);
  assign drop      = cap_v && full && !pop;

  ev_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (cap_e),
    .rdata_o (head_e),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign out_data = head_e.data;

  logic              ovf_q, ovf_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  // A drop in the same cycle as a clear restarts the count at one.
  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (drop) begin
      ovf_d = 1'b1;
      if (clr_ovf)              drop_d = DROP_W'(1);
      else if (drop_q != '1)    drop_d = drop_q + 1'b1;
    end else if (clr_ovf) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end

  assign ovf      = ovf_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_event_capture_queue.sv
// Randomised and directed bench for event_capture_queue; an immediate and a
// deferred instance share stimulus and are checked against a queue model.
module tb_event_capture_queue;

  localparam int DATA_W = 2;
  localparam int DEPTH  = 4;
  localparam int DROP_W = 8;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ev_trig = 1'b0;
  logic [DATA_W-1:0] ev_data = '0;
  logic out_ready = 1'b0;
  logic clr_ovf = 1'b0;

  logic              valid0, valid1, ovf0, ovf1;
  logic [DATA_W-1:0] data0, data1;
  logic [$clog2(DEPTH):0] count0, count1;
  logic [DROP_W-1:0] drop0, drop1;

  int checks = 0;
  int failures = 0;

  int  mq[2][$];
  int  mdrop[2];
  bit  movf[2];
  bit  pend;

  always #5 clk = ~clk;

  event_capture_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SAMPLE_DEFERRED(0), .DROP_W(DROP_W), .TS_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .ev_trig(ev_trig), .ev_data(ev_data),
    .out_valid(valid0), .out_ready(out_ready), .out_data(data0), .count(count0),
    .ovf(ovf0), .clr_ovf(clr_ovf), .drop_cnt(drop0)
  );

  event_capture_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SAMPLE_DEFERRED(1), .DROP_W(DROP_W), .TS_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .ev_trig(ev_trig), .ev_data(ev_data),
    .out_valid(valid1), .out_ready(out_ready), .out_data(data1), .count(count1),
    .ovf(ovf1), .clr_ovf(clr_ovf), .drop_cnt(drop1)
  );

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkDut(input int m, input logic v, input logic [DATA_W-1:0] d,
                          input int c, input logic o, input int dc);
    int sz;
    sz = mq[m].size();
    checkOutput($sformatf("m%0d.valid", m), int'(v), int'(sz > 0));
    checkOutput($sformatf("m%0d.count", m), c, sz);
    checkOutput($sformatf("m%0d.ovf", m), int'(o), int'(movf[m]));
    checkOutput($sformatf("m%0d.drop_cnt", m), dc, mdrop[m]);
    if (sz > 0) checkOutput($sformatf("m%0d.data", m), int'(d), mq[m][0]);
  endtask

  task automatic checkAll();
    checkDut(0, valid0, data0, int'(count0), ovf0, int'(drop0));
    checkDut(1, valid1, data1, int'(count1), ovf1, int'(drop1));
  endtask

  // One clock of the abstract behaviour: pop the head if ready, then append
  // the captured payload if there is room, otherwise count a drop.
  task automatic modelStep();
    bit capV, popNow, dropNow;
    for (int m = 0; m < 2; m++) begin
      capV    = (m == 0) ? ev_trig : pend;
      popNow  = (mq[m].size() > 0) && out_ready;
      dropNow = capV && (mq[m].size() == DEPTH) && !popNow;
      if (popNow) void'(mq[m].pop_front());
      if (capV && !dropNow) mq[m].push_back(int'(ev_data));
      if (dropNow) begin
        movf[m]  = 1'b1;
        mdrop[m] = clr_ovf ? 1 : ((mdrop[m] < DROP_MAX) ? mdrop[m] + 1 : DROP_MAX);
      end else if (clr_ovf) begin
        movf[m]  = 1'b0;
        mdrop[m] = 0;
      end
    end
    pend = ev_trig;
  endtask

  task automatic applyStimulus(input logic trig, input int data, input logic ready, input logic clr);
    @(negedge clk);
    checkAll();
    ev_trig   = trig;
    ev_data   = DATA_W'(data);
    out_ready = ready;
    clr_ovf   = clr;
    modelStep();
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst_n = 1'b0;
    ev_trig = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      mq[m].delete();
      mdrop[m] = 0;
      movf[m]  = 1'b0;
    end
    pend = 1'b0;
    checkAll();
    checkOutput("rst.data0", int'(data0), 0);
    checkOutput("rst.data1", int'(data1), 0);
    @(negedge clk);
    ev_trig = 1'b1;
    @(negedge clk);
    checkAll();
    ev_trig = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1'b0, 0, 1'b1, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 1'b1);
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin mdrop[m] = 0; movf[m] = 1'b0; end
    pend = 1'b0;
    applyReset();

    // Latency: single trigger, data changes the following cycle.
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1, 1'b1, 1'b0);
    applyStimulus(1'b0, 2, 1'b1, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);

    // Overflow: six back-to-back triggers with the consumer stalled.
    drain();
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, i % 4, 1'b0, 1'b0);
    applyStimulus(1'b0, 2, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("ovf.m0.count", int'(count0), 4);
    checkOutput("ovf.m0.drop", int'(drop0), 2);
    checkOutput("ovf.m0.ovf", int'(ovf0), 1);
    checkOutput("ovf.m0.head", int'(data0), 0);

    // Full queue with a simultaneous pop and push: nothing is lost.
    applyStimulus(1'b1, 3, 1'b1, 1'b0);
    applyStimulus(1'b1, 1, 1'b1, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    drain();

    // Saturation of the drop counter, then clear racing a drop, then plain clear.
    for (int i = 0; i < DROP_MAX + 10; i++) applyStimulus(1'b1, i % 4, 1'b0, 1'b0);
    applyStimulus(1'b1, 0, 1'b0, 1'b1);
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    applyStimulus(1'b0, 0, 1'b0, 1'b0);

    // Reset with entries queued and a deferred capture in flight.
    drain();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, i + 1, 1'b0, 1'b0);
    applyReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 3, 1'b1, 1'b0);

    // Random traffic with occasional clears and resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 299) == 0) applyReset();
      applyStimulus(1'($urandom_range(0, 99) < 55), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 99) < 40), 1'($urandom_range(0, 99) < 4));
    end
    applyStimulus(1'b0, 0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
